// File: rtl/voice_pkg.sv
// Shared definitions for the polyphonic voice allocator: message layout,
// voice index width and the allocator FSM encoding.
package voice_pkg;

  localparam int NOTE_W = 7;
  localparam int MSG_ON = 7;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MATCH  = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

endpackage

// File: rtl/voice_search.sv
// Combinational voice search: finds the matching gated voice, the first free
// voice and the oldest gated voice for the note being processed.
module voice_search
  import voice_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8
) (
  input  logic [NUM_VOICES*NOTE_W-1:0] notes_i,
  input  logic [NUM_VOICES-1:0]        gate_i,
  input  logic [NUM_VOICES*AGE_W-1:0]  ages_i,
  input  logic [NOTE_W-1:0]            note_i,
  output logic                         hitFound_o,
  output logic [IDX_W-1:0]             hitIdx_o,
  output logic                         freeFound_o,
  output logic [IDX_W-1:0]             freeIdx_o,
  output logic [IDX_W-1:0]             oldestIdx_o
);

  logic [AGE_W-1:0] bestAge;
  logic             oldFound;

  // Scanning from the top down lets the lowest matching index overwrite any higher one.
  always_comb begin
    hitFound_o  = 1'b0;
    hitIdx_o    = '0;
    freeFound_o = 1'b0;
    freeIdx_o   = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (gate_i[i] && (notes_i[i*NOTE_W +: NOTE_W] == note_i)) begin
        hitFound_o = 1'b1;
        hitIdx_o   = IDX_W'(i);
      end
      if (!gate_i[i]) begin
        freeFound_o = 1'b1;
        freeIdx_o   = IDX_W'(i);
      end
    end
  end

  // Strict greater-than keeps the lowest index when ages tie.
  always_comb begin
    oldestIdx_o = '0;
    bestAge     = '0;
    oldFound    = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (gate_i[i] && (!oldFound || (ages_i[i*AGE_W +: AGE_W] > bestAge))) begin
        oldFound    = 1'b1;
        bestAge     = ages_i[i*AGE_W +: AGE_W];
        oldestIdx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: captures keyboard note-on/off messages and
// assigns them to voice slots, stealing the oldest voice when all are busy.
module voice_alloc
  import voice_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8
) (
  input  logic                         clk_scan_13x,
  input  logic                         rst,
  input  logic                         clk_msg,
  input  logic [7:0]                   msg,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic                         voice_chg,
  output logic [IDX_W-1:0]             voice_idx,
  output logic [7:0]                   drop_cnt
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);

  state_e                        state_q, state_d;
  logic                          clkPrev_q;
  logic [7:0]                    msg_q, msg_d;
  logic [NUM_VOICES*NOTE_W-1:0]  notes_q, notes_d;
  logic [NUM_VOICES-1:0]         gate_q, gate_d;
  logic [NUM_VOICES*AGE_W-1:0]   ages_q, ages_d;
  logic                          chg_q, chg_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [7:0]                    drop_q, drop_d;
  logic                          hit_q, hit_d, free_q, free_d;
  logic [IDX_W-1:0]              hitIdx_q, hitIdx_d, freeIdx_q, freeIdx_d;
  logic [IDX_W-1:0]              oldestIdx_q, oldestIdx_d;

  logic                          msgEdge;
  logic                          srcHit, srcFree;
  logic [IDX_W-1:0]              srcHitIdx, srcFreeIdx, srcOldestIdx;
  logic [IDX_W-1:0]              target;

  voice_search #(
    .NUM_VOICES(NUM_VOICES),
    .AGE_W     (AGE_W)
  ) u_search (
    .notes_i    (notes_q),
    .gate_i     (gate_q),
    .ages_i     (ages_q),
    .note_i     (msg_q[NOTE_W-1:0]),
    .hitFound_o (srcHit),
    .hitIdx_o   (srcHitIdx),
    .freeFound_o(srcFree),
    .freeIdx_o  (srcFreeIdx),
    .oldestIdx_o(srcOldestIdx)
  );

  assign msgEdge = clk_msg & ~clkPrev_q;
  assign target  = hit_q ? hitIdx_q : (free_q ? freeIdx_q : oldestIdx_q);

  always_comb begin
    state_d     = state_q;
    msg_d       = msg_q;
    notes_d     = notes_q;
    gate_d      = gate_q;
    ages_d      = ages_q;
    chg_d       = 1'b0;
    idx_d       = idx_q;
    drop_d      = drop_q;
    hit_d       = hit_q;
    hitIdx_d    = hitIdx_q;
    free_d      = free_q;
    freeIdx_d   = freeIdx_q;
    oldestIdx_d = oldestIdx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (msgEdge) begin
          msg_d   = msg;
          state_d = ST_MATCH;
        end
      end
      ST_MATCH: begin
        state_d     = ST_UPDATE;
        hit_d       = srcHit;
        hitIdx_d    = srcHitIdx;
        free_d      = srcFree;
        freeIdx_d   = srcFreeIdx;
        oldestIdx_d = srcOldestIdx;
      end
      ST_UPDATE: begin
        state_d = ST_IDLE;
        if (msg_q[MSG_ON]) begin
          // A retrigger still ages the other voices but leaves the outputs untouched.
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (IDX_W'(i) == target) begin
              ages_d[i*AGE_W +: AGE_W] = '0;
              if (!hit_q) begin
                notes_d[i*NOTE_W +: NOTE_W] = msg_q[NOTE_W-1:0];
                gate_d[i]                   = 1'b1;
              end
            end else if (gate_q[i] && (ages_q[i*AGE_W +: AGE_W] != AGE_MAX)) begin
              ages_d[i*AGE_W +: AGE_W] = ages_q[i*AGE_W +: AGE_W] + AGE_ONE;
            end
          end
          if (!hit_q) begin
            chg_d = 1'b1;
            idx_d = target;
          end
        end else if (hit_q) begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (IDX_W'(i) == hitIdx_q) begin
              gate_d[i]                = 1'b0;
              ages_d[i*AGE_W +: AGE_W] = '0;
            end
          end
          chg_d = 1'b1;
          idx_d = hitIdx_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (msgEdge && (state_q != ST_IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // History starts at 1 so a strobe already high when reset releases is not a new message.
  always_ff @(posedge clk_scan_13x or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      clkPrev_q   <= 1'b1;
      msg_q       <= '0;
      notes_q     <= '0;
      gate_q      <= '0;
      ages_q      <= '0;
      chg_q       <= 1'b0;
      idx_q       <= '0;
      drop_q      <= '0;
      hit_q       <= 1'b0;
      hitIdx_q    <= '0;
      free_q      <= 1'b0;
      freeIdx_q   <= '0;
      oldestIdx_q <= '0;
    end else begin
      state_q     <= state_d;
      clkPrev_q   <= clk_msg;
      msg_q       <= msg_d;
      notes_q     <= notes_d;
      gate_q      <= gate_d;
      ages_q      <= ages_d;
      chg_q       <= chg_d;
      idx_q       <= idx_d;
      drop_q      <= drop_d;
      hit_q       <= hit_d;
      hitIdx_q    <= hitIdx_d;
      free_q      <= free_d;
      freeIdx_q   <= freeIdx_d;
      oldestIdx_q <= oldestIdx_d;
    end
  end

  assign voice_note = notes_q;
  assign voice_gate = gate_q;
  assign voice_chg  = chg_q;
  assign voice_idx  = idx_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_voice_alloc.sv
// Self-checking bench for voice_alloc: directed scenarios plus random
// note traffic compared against a slot-array reference model.
module tb_voice_alloc;

  localparam int NV = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clk_msg = 1'b0;
  logic [7:0]    msg = 8'd0;
  logic [NV*7-1:0] voice_note;
  logic [NV-1:0] voice_gate;
  logic          voice_chg;
  logic [2:0]    voice_idx;
  logic [7:0]    drop_cnt;

  int nCompared = 0;
  int nMismatched = 0;

  logic [6:0] mNote[NV];
  bit         mGate[NV];
  int         mAge[NV];
  int         mDrop;

  voice_alloc #(.NUM_VOICES(NV), .AGE_W(8)) dut (
    .clk_scan_13x(clk),
    .rst         (rst),
    .clk_msg     (clk_msg),
    .msg         (msg),
    .voice_note  (voice_note),
    .voice_gate  (voice_gate),
    .voice_chg   (voice_chg),
    .voice_idx   (voice_idx),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < NV; i++) begin
      mNote[i] = '0;
      mGate[i] = 1'b0;
      mAge[i]  = 0;
    end
    mDrop = 0;
  endfunction

  // Voices live in a plain array; note-on picks match, else first free, else the most aged voice.
  function automatic void modelApply(input logic [7:0] m, output bit chg, output int idx);
    int hit = -1;
    int free = -1;
    int old = -1;
    int tgt;
    for (int i = 0; i < NV; i++) begin
      if (hit < 0 && mGate[i] && mNote[i] == m[6:0]) hit = i;
      if (free < 0 && !mGate[i]) free = i;
      if (mGate[i] && (old < 0 || mAge[i] > mAge[old])) old = i;
    end
    chg = 1'b0;
    idx = 0;
    if (m[7]) begin
      tgt = (hit >= 0) ? hit : ((free >= 0) ? free : old);
      for (int i = 0; i < NV; i++) begin
        if (i == tgt) mAge[i] = 0;
        else if (mGate[i]) mAge[i] = (mAge[i] >= 255) ? 255 : mAge[i] + 1;
      end
      if (hit < 0) begin
        mNote[tgt] = m[6:0];
        mGate[tgt] = 1'b1;
        chg = 1'b1;
        idx = tgt;
      end
    end else if (hit >= 0) begin
      mGate[hit] = 1'b0;
      mAge[hit]  = 0;
      chg = 1'b1;
      idx = hit;
    end
  endfunction

  function automatic logic [NV*7-1:0] expNotes();
    logic [NV*7-1:0] v = '0;
    for (int i = 0; i < NV; i++) v[i*7 +: 7] = mNote[i];
    return v;
  endfunction

  function automatic logic [NV-1:0] expGates();
    logic [NV-1:0] v = '0;
    for (int i = 0; i < NV; i++) v[i] = mGate[i];
    return v;
  endfunction

  task automatic checkState(input string tag);
    checkOutput({tag, "_note"}, voice_note, expNotes());
    checkOutput({tag, "_gate"}, voice_gate, expGates());
    checkOutput({tag, "_drop"}, drop_cnt, mDrop);
  endtask

  task automatic doReset();
    rst = 1'b1;
    clk_msg = 1'b0;
    msg = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelReset();
    checkState("reset");
    checkOutput("reset_chg", voice_chg, 0);
    checkOutput("reset_idx", voice_idx, 0);
  endtask

  // One message with the strobe held for 'hold' cycles; msg is scrambled after capture.
  task automatic applyStimulus(input logic [7:0] m, input int hold);
    bit ec;
    int ei;
    modelApply(m, ec, ei);
    @(negedge clk);
    clk_msg = 1'b1;
    msg = m;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) msg = 8'($urandom);
      if (c >= hold) clk_msg = 1'b0;
      if (c < 3) checkOutput("chg_early", voice_chg, 0);
    end
    checkOutput("chg", voice_chg, ec);
    if (ec) checkOutput("idx", voice_idx, ei);
    checkState("msg");
    @(negedge clk);
    checkOutput("chg_pulse", voice_chg, 0);
  endtask

  // Two strobe edges 'gap' cycles apart: gap 2 lands in UPDATE, gap 3 back in IDLE.
  task automatic twoEdges(input logic [7:0] m1, input logic [7:0] m2, input int gap);
    bit ec;
    int ei;
    modelApply(m1, ec, ei);
    if (gap >= 3) modelApply(m2, ec, ei);
    else if (mDrop < 255) mDrop++;
    @(negedge clk);
    clk_msg = 1'b1;
    msg = m1;
    @(negedge clk);
    clk_msg = 1'b0;
    repeat (gap - 1) @(negedge clk);
    clk_msg = 1'b1;
    msg = m2;
    @(negedge clk);
    clk_msg = 1'b0;
    repeat (6) @(negedge clk);
    checkState("edges");
  endtask

  initial begin
    logic [7:0] m;
    doReset();

    applyStimulus(8'hBC, 1);
    checkOutput("r27_idx0", voice_idx, 0);
    applyStimulus(8'hC0, 2);
    checkOutput("r27_idx1", voice_idx, 1);
    checkOutput("r27_gate", voice_gate, 4'b0011);
    checkOutput("r27_v1", voice_note[13:7], 64);

    doReset();
    applyStimulus(8'hBC, 1);
    applyStimulus(8'hBE, 1);
    applyStimulus(8'hC0, 1);
    applyStimulus(8'hC1, 1);
    applyStimulus(8'hC3, 3);
    checkOutput("r28_v0", voice_note[6:0], 67);
    checkOutput("r28_gate", voice_gate, 4'b1111);
    checkOutput("r28_idx", voice_idx, 0);

    applyStimulus(8'h3E, 1);
    checkOutput("r29_gate1", voice_gate[1], 0);
    checkOutput("r29_v1", voice_note[13:7], 62);
    applyStimulus(8'h46, 2);

    doReset();
    applyStimulus(8'hBC, 1);
    applyStimulus(8'hBE, 1);
    applyStimulus(8'hC0, 1);
    applyStimulus(8'hC1, 1);
    applyStimulus(8'hBC, 2);
    applyStimulus(8'hC3, 1);
    checkOutput("r30_idx", voice_idx, 1);
    checkOutput("r30_v0", voice_note[6:0], 60);

    doReset();
    twoEdges(8'hBC, 8'hC0, 2);
    checkOutput("r31_drop", drop_cnt, 1);
    twoEdges(8'hC2, 8'hC4, 3);
    checkOutput("r31_gate", voice_gate, 4'b0111);

    @(negedge clk);
    clk_msg = 1'b1;
    msg = 8'hC8;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("r32_note", voice_note, 0);
    checkOutput("r32_gate", voice_gate, 0);
    checkOutput("r32_drop", drop_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("r32_nochg", voice_chg, 0);
    end
    clk_msg = 1'b0;
    checkState("r32");

    doReset();
    for (int n = 0; n < 150; n++) begin
      m[7]   = ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0;
      m[6:0] = 7'(60 + $urandom_range(0, 7));
      applyStimulus(m, int'($urandom_range(1, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
